pipe_wb_stage: RTL
==================

# pipe_wb_stage

Parametrised, elastic MEM/WB pipeline stage. Registers the memory-stage result bundle under a valid/ready handshake with synchronous flush, selects the writeback result, and gates the register-file write enable. Sits between the memory stage and the register-file write port. Replaces fixed-width, always-enabled stage registers so stalls propagate upstream without losing data.

## Interface
Parameters:
- XLEN, 32, data/address width of all datapath fields
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- valid_m  in  1  memory stage presents an entry
- ready_m  out  1  stage can accept an entry
- read_data_m  in  XLEN  load data
- alu_result_m  in  XLEN  ALU result
- pc_plus_4m  in  XLEN  PC+4 for link writes
- result_src_m  in  2  result select
- reg_write_m  in  1  instruction writes rd
- rd_m  in  REG_ADDR_W  destination register
- valid_w  out  1  output entry valid
- ready_w  in  1  writeback consumer accepts
- result_w  out  XLEN  selected writeback value
- reg_write_w  out  1  qualified write enable
- rd_w  out  REG_ADDR_W  destination register
- retire_count  out  64  count of entries consumed at output

## Operation
- Accept: valid_m && ready_m at a rising edge, no flush. Output handshake: valid_w && ready_w.
- result_w by held result_src: 2'b00 alu_result, 2'b01 read_data, 2'b10 pc_plus_4, 2'b11 zero.
- reg_write_w = valid_w && held reg_write && (rd_w != 0); writes to x0 are suppressed.
- result_w, rd_w hold last captured values when valid_w is 0 (don't-care for consumers).
- Output entry persists unchanged while valid_w && !ready_w.
- Simultaneous consume and accept: new entry replaces the consumed one the same edge; no bubble.
- flush: all held entries invalidated at that edge; valid_m on that cycle is discarded; retire_count unaffected. flush with valid_w && ready_w high does not count as a retirement.
- retire_count: +1 per output handshake, wraps 2^64-1 -> 0, cleared only by reset.
- reset: all registers 0, so valid_w=0, reg_write_w=0, result_w=0, rd_w=0, retire_count=0, ready_m=1; asynchronous, takes effect mid-transfer with no partial entries.

## Timing
- Latency: entry accepted at edge N is on outputs after edge N (1 cycle).
- Throughput: 1 entry/cycle while ready_w high.
- result_w, reg_write_w: combinational from held registers only (no input-to-output paths).
- ready_m timing depends on configuration (below).

## Configuration
- PIPE_WB_SKID_EN defined: second (skid) entry added. ready_m = !skid_valid, a pure register output with no combinational path from ready_w. Accept while output held and stalled -> entry goes to skid; ready_m falls the following cycle. On the next output handshake the skid entry moves to output and skid empties. Order preserved. Capacity 2.
- Undefined: single entry, capacity 1. ready_m = !valid_w || ready_w (combinational from ready_w).
- Port list identical in both builds.

## Structure
- Shared package pipe_pkg: result_src_e enum (RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10), default XLEN/REG_ADDR_W localparams.
- Payload packed into one local struct/vector inside the module.
- Sub-module pipe_skid_buf (parameter WIDTH): one-entry holding register with valid. Instantiated only under PIPE_WB_SKID_EN.

## Test plan
- Reset mid-stream: valid_m=1 held, assert reset asynchronously between edges -> valid_w, reg_write_w, retire_count go to 0 immediately; ready_m=1.
- Result select: alu=0x11, mem=0x22, pc4=0x33, src 00/01/10/11 on successive cycles, ready_w=1 -> result_w 0x11, 0x22, 0x33, 0x0, each one cycle after accept.
- x0 suppression: reg_write_m=1, rd_m=0 -> valid_w=1, reg_write_w=0. rd_m=5 -> reg_write_w=1, rd_w=5.
- Back-pressure: stream values 1..4, ready_w low 3 cycles mid-stream -> with skid, ready_m low after second held entry; output order 1,2,3,4, none lost or duplicated. Without skid, ready_m low the same cycle.
- Flush: two entries held (skid build), flush=1 with valid_m=1 -> valid_w=0 next cycle, incoming entry dropped, retire_count unchanged.
- Counter wrap: preload by driving 2^64-1 handshakes via force, one more handshake -> retire_count=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage slice.
//   result_src_e       : writeback result select encoding (2'b11 selects zero)
//   XlenDefault        : default datapath width
//   RegAddrWDefault    : default register index width
package pipe_pkg;

  localparam int unsigned XlenDefault     = 32;
  localparam int unsigned RegAddrWDefault = 5;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'b00,
    RESULT_MEM = 2'b01,
    RESULT_PC4 = 2'b10
  } result_src_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry holding register with a valid flag.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   flush_i     : synchronous clear of the held entry
//   load_i      : capture data_i (takes priority over unload_i)
//   unload_i    : release the held entry
//   data_i      : entry to capture
//   data_o      : held entry
//   valid_o     : held entry is valid
module pipe_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_wb_stage.sv
// Elastic MEM/WB pipeline stage: registers the memory-stage bundle under a valid/ready
// handshake, selects the writeback value and qualifies the register-file write enable.
// Build option: define PIPE_WB_SKID_EN to add a second (skid) entry so that ready_m is a
// pure register output; otherwise a single entry with ready_m = !valid_w || ready_w.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : synchronous kill of all held entries (incoming entry dropped)
//   valid_m / ready_m   : upstream handshake
//   read_data_m, alu_result_m, pc_plus_4m, result_src_m, reg_write_m, rd_m : entry payload
//   valid_w / ready_w   : downstream handshake
//   result_w            : selected writeback value
//   reg_write_w         : write enable, suppressed for x0 and when idle
//   rd_w                : destination register
//   retire_count        : count of output handshakes, wraps, cleared only by reset
module pipe_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN       = XlenDefault,
  parameter int unsigned REG_ADDR_W = RegAddrWDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  valid_m,
  output logic                  ready_m,
  input  logic [XLEN-1:0]       read_data_m,
  input  logic [XLEN-1:0]       alu_result_m,
  input  logic [XLEN-1:0]       pc_plus_4m,
  input  logic [1:0]            result_src_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  output logic                  valid_w,
  input  logic                  ready_w,
  output logic [XLEN-1:0]       result_w,
  output logic                  reg_write_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic [63:0]           retire_count
);

  typedef struct packed {
    logic [XLEN-1:0]       read_data;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       pc_plus_4;
    logic [1:0]            result_src;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } payload_t;

  localparam int unsigned PayloadW = $bits(payload_t);

  payload_t    in_pl;
  payload_t    out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] retire_count_q, retire_count_d;
  logic        accept, pop;

  always_comb begin
    in_pl            = '0;
    in_pl.read_data  = read_data_m;
    in_pl.alu_result = alu_result_m;
    in_pl.pc_plus_4  = pc_plus_4m;
    in_pl.result_src = result_src_m;
    in_pl.reg_write  = reg_write_m;
    in_pl.rd         = rd_m;
  end

  // A flush cycle neither accepts nor retires.
  assign accept = valid_m && ready_m && !flush;
  assign pop    = out_valid_q && ready_w && !flush;

`ifdef PIPE_WB_SKID_EN
  logic                skid_valid, skid_load, skid_unload;
  logic [PayloadW-1:0] skid_data_raw;
  payload_t            skid_data;

  // ready_m depends only on the skid register, so no ready_w -> ready_m path exists.
  assign ready_m     = !skid_valid;
  // Output occupied and stalled: the new entry parks in the skid register.
  assign skid_load   = accept && out_valid_q && !ready_w;
  assign skid_unload = pop && skid_valid;
  assign skid_data   = payload_t'(skid_data_raw);

  pipe_skid_buf #(
    .WIDTH(PayloadW)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (in_pl),
    .data_o   (skid_data_raw),
    .valid_o  (skid_valid)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (skid_unload) begin
      // Skid is older than anything upstream; ready_m was low so nothing was accepted.
      out_valid_d = 1'b1;
      out_d       = skid_data;
    end else if (accept && !skid_load) begin
      out_valid_d = 1'b1;
      out_d       = in_pl;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end
`else
  assign ready_m = !out_valid_q || ready_w;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      // Covers consume-and-accept in the same edge without a bubble.
      out_valid_d = 1'b1;
      out_d       = in_pl;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  assign retire_count_d = retire_count_q + 64'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_q          <= '0;
      retire_count_q <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_q          <= out_d;
      retire_count_q <= retire_count_d;
    end
  end

  always_comb begin
    result_w = '0;
    case (out_q.result_src)
      RESULT_ALU: result_w = out_q.alu_result;
      RESULT_MEM: result_w = out_q.read_data;
      RESULT_PC4: result_w = out_q.pc_plus_4;
      default:    result_w = '0;
    endcase
  end

  assign valid_w      = out_valid_q;
  assign rd_w         = out_q.rd;
  assign reg_write_w  = out_valid_q && out_q.reg_write && (out_q.rd != '0);
  assign retire_count = retire_count_q;

endmodule
